// File: rtl/bram_fetch.sv
// Sequential instruction prefetcher: issues word reads on a simple memory port
// and queues returned words, with their addresses, for an in-order consumer.
module bram_fetch #(
    parameter int unsigned fetch_depth = 4,
    parameter logic [31:0] start_addr  = 32'h0
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        fetch_enable,
    input  logic        fetch_redirect,
    input  logic [31:0] fetch_target,
    input  logic        fetch_take,
    output logic        fetch_ready,
    output logic [31:0] fetch_rdata,
    output logic [31:0] fetch_pc,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    // state | meaning
    // IDLE  | no new requests; responses still in flight are buffered
    // FETCH | issuing sequential requests while buffer space allows
    // FLUSH | after a redirect, dropping stale responses until none remain
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    localparam int PW = $clog2(fetch_depth);
    localparam int CW = $clog2(fetch_depth) + 1;

    state_t        state, state_nxt;
    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target_word;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_nxt;
    logic [CW:0]   occupancy;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   ent_pc   [fetch_depth];
    logic [31:0]   ent_data [fetch_depth];
    logic          issue;
    logic          resp_hit;
    logic          push;
    logic          pop;
    logic          unused_target_lsbs;

    assign target_word        = {fetch_target[31:2], 2'b00};
    assign unused_target_lsbs = ^fetch_target[1:0];

    // Reserving space for in-flight requests means a response always has a free slot.
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign issue     = (state == FETCH) && fetch_enable && !fetch_redirect
                       && (occupancy < (CW+1)'(fetch_depth));
    // A response with nothing outstanding is left over from before a reset.
    assign resp_hit  = mem_ready && (outstanding != '0);
    assign push      = resp_hit && (state != FLUSH) && !fetch_redirect;
    assign pop       = fetch_take && (count != '0) && !fetch_redirect;
    assign out_nxt   = outstanding + CW'(issue) - CW'(resp_hit);

    always_comb begin
        state_nxt = state;
        if (fetch_redirect) begin
            state_nxt = (out_nxt != '0) ? FLUSH : FETCH;
        end else begin
            case (state)
                IDLE:    if (fetch_enable) state_nxt = FETCH;
                FETCH:   if (!fetch_enable) state_nxt = IDLE;
                FLUSH:   if (out_nxt == '0) state_nxt = fetch_enable ? FETCH : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= start_addr;
            resp_pc     <= start_addr;
            count       <= '0;
            outstanding <= '0;
            head        <= '0;
            tail        <= '0;
            mem_valid   <= 1'b0;
            mem_addr    <= 32'h0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            mem_valid   <= issue;
            if (issue) mem_addr <= pc;
            if (fetch_redirect) begin
                pc      <= target_word;
                resp_pc <= target_word;
                count   <= '0;
                head    <= '0;
                tail    <= '0;
            end else begin
                if (issue) pc <= pc + 32'd4;
                // Responses return in order, so the next buffered address is just a running pc.
                if (push) begin
                    tail    <= tail + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) head <= head + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ent_pc[tail]   <= resp_pc;
            ent_data[tail] <= mem_rdata;
        end
    end

    assign fetch_ready = (count != '0);
    assign fetch_pc    = fetch_ready ? ent_pc[head]   : 32'h0;
    assign fetch_rdata = fetch_ready ? ent_data[head] : 32'h0;

    assign mem_instr = 1'b1;
    assign mem_wdata = 32'h0;
    assign mem_wstrb = 4'h0;

endmodule

// File: tb/tb_bram_fetch.sv
// Bench for bram_fetch: in-order responder plus a transaction-level model of
// the expected request stream and consumer-side buffer contents.
module tb_bram_fetch;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_enable, fetch_redirect, fetch_take;
    logic [31:0] fetch_target;
    logic        fetch_ready;
    logic [31:0] fetch_rdata, fetch_pc;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        w_enable, w_ready, w_mem_valid, w_mem_instr;
    logic [31:0] w_rdata, w_pc, w_mem_addr, w_mem_wdata;
    logic [3:0]  w_mem_wstrb;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;

    always #5 clock = ~clock;

    bram_fetch #(.fetch_depth(DEPTH), .start_addr(32'h0)) dut (
        .reset(reset), .clock(clock), .fetch_enable(fetch_enable),
        .fetch_redirect(fetch_redirect), .fetch_target(fetch_target),
        .fetch_take(fetch_take), .fetch_ready(fetch_ready), .fetch_rdata(fetch_rdata),
        .fetch_pc(fetch_pc), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    bram_fetch #(.fetch_depth(DEPTH), .start_addr(32'hFFFF_FFF8)) dut_wrap (
        .reset(reset), .clock(clock), .fetch_enable(w_enable),
        .fetch_redirect(w_zero), .fetch_target(w_zero32),
        .fetch_take(w_zero), .fetch_ready(w_ready), .fetch_rdata(w_rdata),
        .fetch_pc(w_pc), .mem_valid(w_mem_valid), .mem_instr(w_mem_instr),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_wstrb(w_mem_wstrb),
        .mem_rdata(w_zero32), .mem_ready(w_zero)
    );

    typedef struct {
        logic [31:0] a;   // address the DUT asked for
        logic [31:0] e;   // address the stream should have asked for
        int          ep;  // redirect/reset epoch at issue time
    } req_t;

    req_t        pend[$];
    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];
    int          epoch = 0;
    int          cur_ep = -1;
    logic [31:0] cur_e = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] req_exp = 32'h0;
    logic        resp_stall = 1'b0;
    int          resp_pct = 100;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    function automatic logic [64:0] head_exp();
        if (q_pc.size() == 0) return 65'h0;
        return {1'b1, q_pc[0], q_data[0]};
    endfunction

    function automatic int model_out();
        int n = 0;
        foreach (pend[i]) if (pend[i].ep == epoch) n++;
        if (mem_ready && cur_ep == epoch) n++;
        return n;
    endfunction

    // One clock: advance the model with the inputs seen at this edge, then
    // drive the responder for the next cycle and log any new request.
    task automatic tick();
        logic acc;
        req_t r;
        @(posedge clock);
        #1;
        if (reset) begin
            q_pc.delete();
            q_data.delete();
            epoch++;
            exp_pc = 32'h0;
        end else begin
            acc = mem_ready && (cur_ep == epoch) && !fetch_redirect;
            if (fetch_redirect) begin
                q_pc.delete();
                q_data.delete();
                epoch++;
                exp_pc = {fetch_target[31:2], 2'b00};
            end else begin
                if (fetch_take && q_pc.size() > 0) begin
                    void'(q_pc.pop_front());
                    void'(q_data.pop_front());
                end
                if (acc) begin
                    q_pc.push_back(cur_e);
                    q_data.push_back(word_of(cur_e));
                end
            end
        end
        if (pend.size() > 0 && !resp_stall && $urandom_range(99) < resp_pct) begin
            r = pend.pop_front();
            mem_ready = 1'b1;
            mem_rdata = word_of(r.a);
            cur_ep    = r.ep;
            cur_e     = r.e;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            cur_ep    = -1;
        end
        req_exp = exp_pc;
        if (mem_valid) begin
            r.a = mem_addr;
            r.e = exp_pc;
            r.ep = epoch;
            pend.push_back(r);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        pend.delete();
        fetch_enable = 0; fetch_take = 0; fetch_redirect = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        fetch_enable = 1; fetch_take = 1; fetch_redirect = 0; w_enable = 1;
        reset = 1;
        tick();
        tick();
        total++;
        if ({fetch_ready, fetch_pc, fetch_rdata, mem_valid, mem_addr, mem_instr, mem_wdata, mem_wstrb}
            !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b pc=%h rd=%h mv=%b ma=%h mi=%b wd=%h ws=%h",
                     fetch_ready, fetch_pc, fetch_rdata, mem_valid, mem_addr, mem_instr, mem_wdata, mem_wstrb);
        end
        total++;
        if ({w_ready, w_pc, w_rdata, w_mem_valid, w_mem_addr, w_mem_instr, w_mem_wdata, w_mem_wstrb}
            !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset_outputs_wrap got rdy=%b mv=%b ma=%h", w_ready, w_mem_valid, w_mem_addr);
        end
        w_enable = 0;
        fetch_enable = 0;
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (mem_valid !== 1'b0 || fetch_ready !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet got mv=%b rdy=%b want 0 0", mem_valid, fetch_ready);
            end
        end
    endtask

    task automatic test_stream();
        int nreq = 0;
        int nhead = 0;
        do_reset();
        resp_pct = 100; resp_stall = 0;
        fetch_enable = 1; fetch_take = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            total++;
            if ({fetch_ready, fetch_pc, fetch_rdata} !== head_exp()) begin
                bad++;
                $display("FAIL stream_head got=%h want=%h", {fetch_ready, fetch_pc, fetch_rdata}, head_exp());
            end
            if (nreq > 0 || mem_valid) begin
                total++;
                if (mem_valid !== 1'b1 || mem_addr !== 32'(nreq * 4)) begin
                    bad++;
                    $display("FAIL stream_addr got mv=%b addr=%h want 1 %h", mem_valid, mem_addr, 32'(nreq * 4));
                end
                nreq++;
            end
            if (nhead > 0 || fetch_ready) begin
                total++;
                if (fetch_ready !== 1'b1 || fetch_pc !== 32'(nhead * 4) || fetch_rdata !== 32'(nhead)) begin
                    bad++;
                    $display("FAIL stream_out got rdy=%b pc=%h rd=%h want 1 %h %h",
                             fetch_ready, fetch_pc, fetch_rdata, 32'(nhead * 4), 32'(nhead));
                end
                nhead++;
            end
        end
        total++;
        if (nreq < 36 || nhead < 34) begin
            bad++;
            $display("FAIL stream_start got req=%0d out=%0d want >=36 >=34", nreq, nhead);
        end
        fetch_enable = 0; fetch_take = 0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [31:0] a = 32'hDEAD_BEEF;
        do_reset();
        resp_pct = 100; resp_stall = 0;
        fetch_enable = 1; fetch_take = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_valid) n++;
        end
        total++;
        if (n !== 4 || fetch_ready !== 1'b1 || mem_valid !== 1'b0 || fetch_pc !== 32'h0) begin
            bad++;
            $display("FAIL bp_fill got reqs=%0d rdy=%b mv=%b pc=%h want 4 1 0 0", n, fetch_ready, mem_valid, fetch_pc);
        end
        fetch_take = 1;
        tick();
        fetch_take = 0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_valid) begin n++; a = mem_addr; end
            total++;
            if ({fetch_ready, fetch_pc, fetch_rdata} !== head_exp()) begin
                bad++;
                $display("FAIL bp_head got=%h want=%h", {fetch_ready, fetch_pc, fetch_rdata}, head_exp());
            end
        end
        total++;
        if (n !== 1 || a !== 32'h10 || fetch_pc !== 32'h4) begin
            bad++;
            $display("FAIL bp_one_more got reqs=%0d addr=%h pc=%h want 1 00000010 00000004", n, a, fetch_pc);
        end
        fetch_enable = 0;
    endtask

    // Leaves exactly two requests in flight with the responder held off.
    task automatic two_outstanding(input string tag);
        int n = 0;
        do_reset();
        resp_pct = 100; resp_stall = 1;
        fetch_enable = 1; fetch_take = 0;
        for (int c = 0; c < 10 && n < 2; c++) begin
            tick();
            if (mem_valid) n++;
        end
        fetch_enable = 0;
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL %s_issue got reqs=%0d want 2 within 10 cycles", tag, n);
        end
    endtask

    task automatic test_redirect();
        int first_req = -1;
        logic [31:0] a = 32'h0;
        logic [64:0] h = 65'h0;
        two_outstanding("redir");
        tick();
        total++;
        if (mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_hold got mv=%b want 0", mem_valid);
        end
        fetch_redirect = 1; fetch_target = 32'h100 | 32'($urandom_range(3)); fetch_enable = 1;
        tick();
        fetch_redirect = 0;
        resp_stall = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (first_req < 0 && mem_valid) begin first_req = c; a = mem_addr; end
            if (h == 65'h0 && fetch_ready) h = {fetch_ready, fetch_pc, fetch_rdata};
            total++;
            if ({fetch_ready, fetch_pc, fetch_rdata} !== head_exp()) begin
                bad++;
                $display("FAIL redir_head got=%h want=%h", {fetch_ready, fetch_pc, fetch_rdata}, head_exp());
            end
        end
        total++;
        if (first_req < 0 || a !== 32'h100) begin
            bad++;
            $display("FAIL redir_addr got first=%0d addr=%h want 00000100", first_req, a);
        end
        total++;
        if (h !== {1'b1, 32'h100, 32'h40}) begin
            bad++;
            $display("FAIL redir_first_out got=%h want=%h", h, {1'b1, 32'h100, 32'h40});
        end
        fetch_enable = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] seen[$];
        do_reset();
        w_enable = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (w_mem_valid) seen.push_back(w_mem_addr);
        end
        w_enable = 0;
        total++;
        if (seen.size() !== 4) begin
            bad++;
            $display("FAIL wrap_count got=%0d want 4", seen.size());
        end else begin
            total++;
            if (seen[0] !== 32'hFFFF_FFF8 || seen[1] !== 32'hFFFF_FFFC || seen[2] !== 32'h0 || seen[3] !== 32'h4) begin
                bad++;
                $display("FAIL wrap_addr got %h %h %h %h want fffffff8 fffffffc 00000000 00000004",
                         seen[0], seen[1], seen[2], seen[3]);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        resp_pct = 100; resp_stall = 0;
        fetch_enable = 1; fetch_take = 0;
        repeat (12) tick();
        total++;
        if (q_pc.size() !== DEPTH || {fetch_ready, fetch_pc, fetch_rdata} !== head_exp()) begin
            bad++;
            $display("FAIL sim_full got=%h want=%h model=%0d", {fetch_ready, fetch_pc, fetch_rdata}, head_exp(), q_pc.size());
        end
        fetch_enable = 0; fetch_redirect = 1; fetch_take = 1; fetch_target = 32'h2000;
        tick();
        fetch_redirect = 0; fetch_take = 0;
        total++;
        if ({fetch_ready, fetch_pc, fetch_rdata} !== 65'h0) begin
            bad++;
            $display("FAIL sim_redir_take got=%h want 0", {fetch_ready, fetch_pc, fetch_rdata});
        end
        fetch_enable = 1;
        repeat (12) tick();
        fetch_take = 1;
        for (int c = 0; c < 30; c++) begin
            tick();
            total++;
            if (fetch_ready !== 1'b1 || {fetch_ready, fetch_pc, fetch_rdata} !== head_exp()) begin
                bad++;
                $display("FAIL sim_take_full got=%h want=%h", {fetch_ready, fetch_pc, fetch_rdata}, head_exp());
            end
        end
        fetch_take = 0;
        repeat (8) tick();
        total++;
        if (q_pc.size() !== DEPTH || {fetch_ready, fetch_pc, fetch_rdata} !== head_exp()) begin
            bad++;
            $display("FAIL sim_refull got=%h want=%h", {fetch_ready, fetch_pc, fetch_rdata}, head_exp());
        end
        fetch_enable = 0;
    endtask

    task automatic test_reset_mid();
        two_outstanding("rstmid");
        reset = 1;
        tick();
        total++;
        if ({fetch_ready, fetch_pc, fetch_rdata, mem_valid, mem_addr} !== {1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL rstmid_outputs got rdy=%b pc=%h rd=%h mv=%b ma=%h",
                     fetch_ready, fetch_pc, fetch_rdata, mem_valid, mem_addr);
        end
        reset = 0;
        resp_stall = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            total++;
            if (fetch_ready !== 1'b0 || mem_valid !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_late got rdy=%b mv=%b want 0 0", fetch_ready, mem_valid);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        resp_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(2))
                    0:       resp_pct = 100;
                    1:       resp_pct = 50;
                    default: resp_pct = 20;
                endcase
            end
            fetch_enable   = ($urandom_range(99) < 80);
            fetch_take     = ($urandom_range(99) < 60);
            fetch_redirect = ($urandom_range(99) < 3);
            fetch_target   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom;
            tick();
            fetch_redirect = 0;
            total++;
            if ({fetch_ready, fetch_pc, fetch_rdata} !== head_exp()) begin
                bad++;
                $display("FAIL rand_head c=%0d got=%h want=%h", c, {fetch_ready, fetch_pc, fetch_rdata}, head_exp());
            end
            if (mem_valid) begin
                total++;
                if (mem_addr !== req_exp) begin
                    bad++;
                    $display("FAIL rand_addr c=%0d got=%h want=%h", c, mem_addr, req_exp);
                end
            end
            total++;
            if (q_pc.size() + model_out() > DEPTH) begin
                bad++;
                $display("FAIL rand_capacity c=%0d got=%0d want<=%0d", c, q_pc.size() + model_out(), DEPTH);
            end
        end
        fetch_enable = 0; fetch_take = 0;
    endtask

    initial begin
        reset = 1; fetch_enable = 0; fetch_redirect = 0; fetch_take = 0;
        fetch_target = 32'h0; w_enable = 0; mem_ready = 0; mem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
